// File: rtl/io_line_pkg.sv
// Shared sizing helpers for the kfpga IO line.
// The bitstream generator uses the same derivations.
package io_line_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Per tile: each pad has an IC selector plus a reg-mode bit.
  // Each wire has an IO selector.
  function automatic int unsigned cfg_per_tile(input int unsigned io_per_tile,
                                               input int unsigned ic_per_tile);
    return io_per_tile * (clog2(ic_per_tile) + 1) + ic_per_tile * clog2(io_per_tile);
  endfunction

  function automatic int unsigned cfg_total(input int unsigned tiles,
                                            input int unsigned io_per_tile,
                                            input int unsigned ic_per_tile);
    return tiles * cfg_per_tile(io_per_tile, ic_per_tile);
  endfunction

endpackage

// File: rtl/io_tile_cfg.sv
// One IO tile: pad/wire source muxes and the optional pad output registers.
// The tile is driven from its slice of the committed configuration.
module io_tile_cfg
  import io_line_pkg::*;
#(
  parameter int unsigned IO_PER_TILE = 4,
  parameter int unsigned IC_PER_TILE = 6
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic [cfg_per_tile(IO_PER_TILE, IC_PER_TILE)-1:0] cfg,
  input  logic [IO_PER_TILE-1:0]                         data_from_io,
  output logic [IO_PER_TILE-1:0]                         data_to_io,
  input  logic [IC_PER_TILE-1:0]                         data_from_ic,
  output logic [IC_PER_TILE-1:0]                         data_to_ic
);

  localparam int unsigned SEL_IC   = clog2(IC_PER_TILE);
  localparam int unsigned SEL_IO   = clog2(IO_PER_TILE);
  localparam int unsigned WIRE_LSB = IO_PER_TILE * (SEL_IC + 1);

  for (genvar p = 0; p < IO_PER_TILE; p++) begin : g_pad
    logic [SEL_IC-1:0] sel;
    logic              reg_mode;
    logic              src;
    logic              pad_q;

    assign sel      = cfg[p*(SEL_IC+1) +: SEL_IC];
    assign reg_mode = cfg[p*(SEL_IC+1) + SEL_IC];

    // Selector codes past the last wire fall through to 0.
    always_comb begin
      src = 1'b0;
      for (int i = 0; i < IC_PER_TILE; i++) begin
        if (sel == SEL_IC'(i)) src = data_from_ic[i];
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) pad_q <= 1'b0;
      else       pad_q <= src;
    end

    assign data_to_io[p] = reg_mode ? pad_q : src;
  end

  for (genvar w = 0; w < IC_PER_TILE; w++) begin : g_wire
    logic [SEL_IO-1:0] sel;

    assign sel = cfg[WIRE_LSB + w*SEL_IO +: SEL_IO];

    always_comb begin
      data_to_ic[w] = 1'b0;
      for (int i = 0; i < IO_PER_TILE; i++) begin
        if (sel == SEL_IO'(i)) data_to_ic[w] = data_from_io[i];
      end
    end
  end

endmodule

// File: rtl/io_line_cfg.sv
// Row of IO tiles with a daisy-chainable serial config chain.
// Config is committed atomically once the last bit has arrived.
module io_line_cfg
  import io_line_pkg::*;
#(
  parameter int unsigned TILES       = 3,
  parameter int unsigned IO_PER_TILE = 4,
  parameter int unsigned IC_PER_TILE = 6
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           config_start,
  input  logic                           config_valid,
  input  logic                           config_in,
  output logic                           config_out,
  output logic                           config_done,
  input  logic [TILES*IO_PER_TILE-1:0]   data_from_io,
  output logic [TILES*IO_PER_TILE-1:0]   data_to_io,
  input  logic [TILES*IC_PER_TILE-1:0]   data_from_ic,
  output logic [TILES*IC_PER_TILE-1:0]   data_to_ic
);

  localparam int unsigned CFG_PER_TILE = cfg_per_tile(IO_PER_TILE, IC_PER_TILE);
  localparam int unsigned CFG_TOTAL    = cfg_total(TILES, IO_PER_TILE, IC_PER_TILE);
  localparam int unsigned CNT_W        = clog2(CFG_TOTAL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_TOTAL);

  logic [CFG_TOTAL-1:0] chain_q, chain_d, active_q;
  logic [CNT_W-1:0]     count_q;
  logic                 done_q;

  assign chain_d = {config_in, chain_q[CFG_TOTAL-1:1]};

  // The active register is only written on the bit that completes a load.
  // It is left alone by config_start, so routing holds steady during a reload.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q  <= '0;
      active_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      if (config_valid) chain_q <= chain_d;
      if (config_start) begin
        count_q <= config_valid ? CNT_W'(1) : '0;
        done_q  <= 1'b0;
      end else if (config_valid && (count_q != CNT_MAX)) begin
        count_q <= count_q + CNT_W'(1);
        if (count_q == CNT_MAX - CNT_W'(1)) begin
          active_q <= chain_d;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign config_out  = chain_q[0];
  assign config_done = done_q;

  for (genvar t = 0; t < TILES; t++) begin : g_tile
    io_tile_cfg #(
      .IO_PER_TILE(IO_PER_TILE),
      .IC_PER_TILE(IC_PER_TILE)
    ) u_tile (
      .clock       (clock),
      .reset       (reset),
      .cfg         (active_q[t*CFG_PER_TILE +: CFG_PER_TILE]),
      .data_from_io(data_from_io[t*IO_PER_TILE +: IO_PER_TILE]),
      .data_to_io  (data_to_io[t*IO_PER_TILE +: IO_PER_TILE]),
      .data_from_ic(data_from_ic[t*IC_PER_TILE +: IC_PER_TILE]),
      .data_to_ic  (data_to_ic[t*IC_PER_TILE +: IC_PER_TILE])
    );
  end

endmodule
